// File: rtl/vote_session_collector.sv
// Ballot session collector: opens a session, takes one vote per voter over a
// valid/ready handshake, rejects bad votes, closes and resolves the outcome.
module vote_session_collector #(
  parameter int N_VOTERS = 15,
  parameter int ID_W     = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_i,
  input  logic             chair_i,
  input  logic             close_i,
  input  logic             vote_valid_i,
  output logic             vote_ready_o,
  input  logic [ID_W-1:0]  vote_id_i,
  input  logic [1:0]       vote_val_i,
  output logic [CNT_W-1:0] yes_cnt_o,
  output logic [CNT_W-1:0] no_cnt_o,
  output logic [CNT_W-1:0] abs_cnt_o,
  output logic             result_o,
  output logic             result_valid_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [1:0]       state_o
);

  // Handshake: a vote transfers on any rising edge where vote_valid_i and
  // vote_ready_o are both high; vote_ready_o depends only on the state.
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [N_VOTERS:1]  r_voted;
  logic [CNT_W-1:0]   r_yes, r_no, r_abs, r_acc_cnt;
  logic               r_chair, r_result, r_err;
  logic [1:0]         r_err_code;

  logic               w_open, w_hs, w_bad_id, w_illegal, w_dup, w_reject, w_accept, w_last;
  logic [1:0]         w_code;

  assign w_open    = open_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs      = vote_valid_i && (r_state == S_COLLECT);
  assign w_bad_id  = (vote_id_i == '0) || (vote_id_i > ID_W'(N_VOTERS));
  assign w_illegal = (vote_val_i == 2'b11);

  always_comb begin
    w_dup = 1'b0;
    for (int i = 1; i <= N_VOTERS; i++) begin
      if (vote_id_i == ID_W'(i) && r_voted[i]) w_dup = 1'b1;
    end
  end

  assign w_reject = w_bad_id || w_illegal || w_dup;
  assign w_accept = w_hs && !w_reject;
  assign w_code   = w_bad_id ? 2'b01 : (w_illegal ? 2'b11 : 2'b10);
  assign w_last   = w_accept && (r_acc_cnt == CNT_W'(N_VOTERS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_open) w_next_state = S_COLLECT;
      S_COLLECT: if (close_i || w_last) w_next_state = S_DECIDE;
      S_DECIDE:  w_next_state = S_DONE;
      S_DONE:    if (w_open) w_next_state = S_COLLECT;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    vote_ready_o   = (r_state == S_COLLECT);
    result_valid_o = (r_state == S_DONE);
    state_o        = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_voted    <= '0;
      r_yes      <= '0;
      r_no       <= '0;
      r_abs      <= '0;
      r_acc_cnt  <= '0;
      r_chair    <= 1'b0;
      r_result   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_err <= 1'b0;
      if (w_open) begin
        r_voted    <= '0;
        r_yes      <= '0;
        r_no       <= '0;
        r_abs      <= '0;
        r_acc_cnt  <= '0;
        r_err_code <= 2'b00;
        r_chair    <= chair_i;
      end
      if (w_hs && w_reject) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
      if (w_accept) begin
        r_voted[vote_id_i] <= 1'b1;
        r_acc_cnt          <= r_acc_cnt + CNT_W'(1);
        case (vote_val_i)
          2'b01:   r_yes <= r_yes + CNT_W'(1);
          2'b00:   r_no  <= r_no + CNT_W'(1);
          default: r_abs <= r_abs + CNT_W'(1);
        endcase
      end
      // Ties, including an empty session, fall to the chair bit.
      if (r_state == S_DECIDE) begin
        if (r_yes > r_no)      r_result <= 1'b1;
        else if (r_yes < r_no) r_result <= 1'b0;
        else                   r_result <= r_chair;
      end
    end
  end

  assign yes_cnt_o  = r_yes;
  assign no_cnt_o   = r_no;
  assign abs_cnt_o  = r_abs;
  assign result_o   = r_result;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

endmodule

// File: tb/tb_vote_session_collector.sv
// Self-checking bench for vote_session_collector: directed scenarios plus
// randomized sessions compared against a cycle-level behavioural model.
module tb_vote_session_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       open_i = 1'b0, chair_i = 1'b0, close_i = 1'b0, vote_valid_i = 1'b0;
  logic [3:0] vote_id_i = '0;
  logic [1:0] vote_val_i = '0;
  logic       vote_ready_o, result_o, result_valid_o, err_o;
  logic [3:0] yes_cnt_o, no_cnt_o, abs_cnt_o;
  logic [1:0] err_code_o, state_o;

  int n_checks = 0;
  int n_fail   = 0;

  vote_session_collector #(.N_VOTERS(15), .ID_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .open_i(open_i), .chair_i(chair_i), .close_i(close_i),
    .vote_valid_i(vote_valid_i), .vote_ready_o(vote_ready_o), .vote_id_i(vote_id_i),
    .vote_val_i(vote_val_i), .yes_cnt_o(yes_cnt_o), .no_cnt_o(no_cnt_o),
    .abs_cnt_o(abs_cnt_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .err_o(err_o), .err_code_o(err_code_o), .state_o(state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural model: phase 0 idle, 1 collecting, 2 deciding, 3 done
  int m_phase, m_yes, m_no, m_abs, m_total, m_code;
  bit m_voted[16];
  bit m_chair, m_result, m_err;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_yes = 0; m_no = 0; m_abs = 0; m_total = 0; m_code = 0;
    m_chair = 0; m_result = 0; m_err = 0;
    foreach (m_voted[i]) m_voted[i] = 0;
  endtask

  task automatic check_outputs();
    check("ready", vote_ready_o, m_phase == 1);
    check("result_valid", result_valid_o, m_phase == 3);
    check("err", err_o, m_err);
    check("err_code", err_code_o, m_code);
    check("yes", yes_cnt_o, m_yes);
    check("no", no_cnt_o, m_no);
    check("abs", abs_cnt_o, m_abs);
    if (m_phase == 3) check("result", result_o, m_result);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_result", result_o, 0);
    check_outputs();
  endtask

  // one clock of stimulus, followed by the model update and output check
  task automatic cycle(input bit op, input bit ch, input bit cl, input bit v,
                       input int id, input int val);
    open_i = op; chair_i = ch; close_i = cl; vote_valid_i = v;
    vote_id_i = 4'(id); vote_val_i = 2'(val);
    @(posedge clk); #1;
    open_i = 0; close_i = 0; vote_valid_i = 0;
    m_err = 0;
    case (m_phase)
      0, 3: if (op) begin
        m_phase = 1; m_yes = 0; m_no = 0; m_abs = 0; m_total = 0; m_code = 0;
        m_chair = ch;
        foreach (m_voted[i]) m_voted[i] = 0;
      end
      1: begin
        if (v) begin
          if (id == 0 || id > 15)  begin m_err = 1; m_code = 1; end
          else if (val == 3)       begin m_err = 1; m_code = 3; end
          else if (m_voted[id])    begin m_err = 1; m_code = 2; end
          else begin
            m_voted[id] = 1;
            m_total++;
            if (val == 1) m_yes++;
            else if (val == 0) m_no++;
            else m_abs++;
          end
        end
        if (cl || m_total == 15) m_phase = 2;
      end
      2: begin
        m_result = (m_yes > m_no) ? 1'b1 : (m_yes < m_no) ? 1'b0 : m_chair;
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic full_session(input bit ch, input int n_yes, input int n_no);
    cycle(1, ch, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++)
      cycle(0, 0, 0, 1, i, (i <= n_yes) ? 1 : (i <= n_yes + n_no) ? 0 : 2);
    check("ready_after_last", vote_ready_o, 0);
    idle();
    check("valid_two_edges", result_valid_o, 1);
  endtask

  initial begin
    do_reset();

    // full session, 8 yes / 7 no, chair 0
    full_session(0, 8, 7);
    check("res_8_7", result_o, 1);
    // ties settled by the chair bit
    full_session(1, 5, 5);
    check("tie_chair1", result_o, 1);
    full_session(0, 5, 5);
    check("tie_chair0", result_o, 0);

    // rejection codes
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 3, 1);
    cycle(0, 0, 0, 1, 3, 0);
    check("dup_code", err_code_o, 2);
    cycle(0, 0, 0, 1, 0, 1);
    check("bad_id_code", err_code_o, 1);
    cycle(0, 0, 0, 1, 5, 3);
    check("illegal_code", err_code_o, 3);
    idle();
    check("err_one_cycle", err_o, 0);
    cycle(0, 0, 0, 1, 3, 3);
    check("bad_over_dup", err_code_o, 3);
    cycle(0, 0, 1, 0, 0, 0);
    idle();

    // close with no votes, then close together with a vote
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    idle();
    check("empty_chair", result_o, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 7, 1);
    check("close_vote_yes", yes_cnt_o, 1);
    idle();
    check("close_vote_res", result_o, 1);

    // DONE ignores votes and close; open restarts
    cycle(0, 0, 0, 1, 9, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("done_hold", result_o, 1);
    cycle(1, 0, 0, 0, 0, 0);
    check("reopen_valid", result_valid_o, 0);

    // mid-session reset, ignored open while collecting
    for (int i = 1; i <= 6; i++) cycle(0, 0, 0, 1, i, i % 3);
    cycle(1, 1, 0, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) cycle(0, 0, 0, 1, i, 1);
    check("revote_yes", yes_cnt_o, 6);
    cycle(0, 0, 1, 0, 0, 0);
    idle();

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      cycle(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      for (int k = 0; k < 60 && m_phase == 1; k++)
        cycle($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15), $urandom_range(0, 6) == 0 ? 3 : $urandom_range(0, 2));
      if (m_phase == 1) cycle(0, 0, 1, 0, 0, 0);
      idle();
      check("rand_done", result_valid_o, 1);
      if ($urandom_range(0, 7) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
